// File: rtl/alu_nibble_sequencer_if.sv
// Host and 4-bit slice signals of alu_nibble_sequencer in one bundle.
// ALU_SEQ_ZERO_EN adds the registered 'zero' result flag.
interface alu_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       sel;
    logic             mode;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             a_eq_b;
`ifdef ALU_SEQ_ZERO_EN
    logic             zero;
`endif
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_cn;
    logic [3:0]       alu_f;
    logic             alu_cn_out;
    logic             alu_a_eq_b;

`ifdef ALU_SEQ_ZERO_EN
    modport slave (
        input  start, op_a, op_b, sel, mode, carry_in,
        output busy, done, result, carry_out, a_eq_b, zero,
        output alu_a, alu_b, alu_s, alu_m, alu_cn,
        input  alu_f, alu_cn_out, alu_a_eq_b
    );
    modport master (
        output start, op_a, op_b, sel, mode, carry_in,
        input  busy, done, result, carry_out, a_eq_b, zero,
        input  alu_a, alu_b, alu_s, alu_m, alu_cn,
        output alu_f, alu_cn_out, alu_a_eq_b
    );
`else
    modport slave (
        input  start, op_a, op_b, sel, mode, carry_in,
        output busy, done, result, carry_out, a_eq_b,
        output alu_a, alu_b, alu_s, alu_m, alu_cn,
        input  alu_f, alu_cn_out, alu_a_eq_b
    );
    modport master (
        output start, op_a, op_b, sel, mode, carry_in,
        input  busy, done, result, carry_out, a_eq_b,
        input  alu_a, alu_b, alu_s, alu_m, alu_cn,
        output alu_f, alu_cn_out, alu_a_eq_b
    );
`endif
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs a WIDTH-bit op through one external 74181 slice, one nibble per clock, LSB first.
// ALU_SEQ_ZERO_EN adds a registered zero-result flag.
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst,
    alu_nibble_sequencer_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_lat, b_lat, result_r, result_nxt;
    logic [3:0]       s_lat;
    logic             m_lat, cin_lat;
    logic [IW-1:0]    idx;
    logic             cy_reg, eq_acc;
    logic             busy, done;
    logic             last;

    assign last = (idx == IW'(NIB - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        result_nxt             = result_r;
        result_nxt[4*idx +: 4] = bus.alu_f;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_lat    <= '0;
            b_lat    <= '0;
            s_lat    <= '0;
            m_lat    <= 1'b0;
            cin_lat  <= 1'b0;
            idx      <= '0;
            result_r <= '0;
            cy_reg   <= 1'b1;
            eq_acc   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_lat   <= bus.op_a;
                    b_lat   <= bus.op_b;
                    s_lat   <= bus.sel;
                    m_lat   <= bus.mode;
                    cin_lat <= bus.carry_in;
                    idx     <= '0;
                    eq_acc  <= 1'b1;
                end
                RUN: begin
                    result_r <= result_nxt;
                    cy_reg   <= bus.alu_cn_out;
                    eq_acc   <= eq_acc & bus.alu_a_eq_b;
                    // Parking idx at 0 makes IDLE/DONE present nibble 0.
                    idx      <= last ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_EN
    logic zero_r;
    always_ff @(posedge clk) begin
        if (rst)                        zero_r <= 1'b0;
        else if (state == RUN && last) zero_r <= (result_nxt == '0);
    end
    assign bus.zero = zero_r;
`endif

    // Carry chains raw between passes; nibble 0 takes the latched carry_in.
    assign bus.alu_a     = a_lat[4*idx +: 4];
    assign bus.alu_b     = b_lat[4*idx +: 4];
    assign bus.alu_s     = s_lat;
    assign bus.alu_m     = m_lat;
    assign bus.alu_cn    = (idx == '0) ? cin_lat : cy_reg;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result_r;
    assign bus.carry_out = cy_reg;
    assign bus.a_eq_b    = eq_acc;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer (WIDTH=16) with a behavioural 74181 slice attached.
module tb_alu_nibble_sequencer;
    logic clk, rst;
    int   n_total = 0;
    int   n_pass  = 0;

    alu_nibble_sequencer_if #(.WIDTH(16)) bus ();
    alu_nibble_sequencer #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74181, active-high data: F = X plus Y plus ~Cn (arith), F = ~(X^Y) (logic).
    function automatic logic [5:0] slice(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s, input logic m, input logic cn);
        logic [3:0] x, y, f;
        logic [4:0] sum;
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cn};
        f   = m ? ~(x ^ y) : sum[3:0];
        return {&f, ~sum[4], f};
    endfunction

    logic [5:0] slice_out;
    assign slice_out      = slice(bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_cn);
    assign bus.alu_f      = slice_out[3:0];
    assign bus.alu_cn_out = slice_out[4];
    assign bus.alu_a_eq_b = slice_out[5];

    typedef struct {
        logic [15:0] a, b;
        logic [3:0]  s;
        logic        m, cn;
        logic [15:0] res;
        logic        cout, chk_cout, eq;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic drive(input vec_t v, input logic st);
        bus.op_a = v.a; bus.op_b = v.b; bus.sel = v.s;
        bus.mode = v.m; bus.carry_in = v.cn; bus.start = st;
    endtask

    // Called at a negedge; drives start there and follows the op to done.
    task automatic run_op(input vec_t v, input int id);
        int lat, bcnt;
        logic [15:0] aseq;
        drive(v, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1; bcnt = 0; aseq = '0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) begin
                bcnt++;
                aseq = {aseq[11:0], bus.alu_a};
            end
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", id), lat, 5);
        chk($sformatf("v%0d busy_cycles", id), bcnt, 4);
        chk($sformatf("v%0d result", id), bus.result, v.res);
        if (v.chk_cout) chk($sformatf("v%0d carry_out", id), bus.carry_out, v.cout);
        chk($sformatf("v%0d a_eq_b", id), bus.a_eq_b, v.eq);
`ifdef ALU_SEQ_ZERO_EN
        chk($sformatf("v%0d zero", id), bus.zero, (v.res == 16'h0) ? 1 : 0);
`endif
        if (id == 0) begin
            chk("v0 alu_a_seq", aseq, 16'h4321);
            chk("v0 alu_a_done_nib0", bus.alu_a, 4'h4);
        end
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", id), bus.done, 0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b1, 16'h2201, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hA5A5, 16'h0000, 4'b0000, 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'hA5A5, 16'h0FF0, 4'b1011, 1'b1, 1'b1, 16'h05A0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h5555, 16'h5555, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{16'h5555, 16'h5554, 4'b0110, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h1234, 16'h0234, 4'b0110, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{16'h000F, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        drive(vecs[2], 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst result", bus.result, 0);
        chk("rst carry_out", bus.carry_out, 1);
        chk("rst a_eq_b", bus.a_eq_b, 0);
        chk("rst alu_a", bus.alu_a, 0);
        chk("rst alu_s", bus.alu_s, 0);
`ifdef ALU_SEQ_ZERO_EN
        chk("rst zero", bus.zero, 0);
`endif
        @(negedge clk);

        // Back-to-back: each run_op starts in the cycle after the previous done.
        for (int i = 0; i < 9; i++) run_op(vecs[i], i);

        // Start pulsed mid-RUN with other operands is dropped, not queued.
        drive(vecs[0], 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        drive(vecs[1], 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !bus.done; c++) @(negedge clk);
        chk("ign done_seen", bus.done, 1);
        chk("ign result", bus.result, 16'h2201);
        chk("ign carry_out", bus.carry_out, 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("ign no_second_op", seen, 0);

        // Reset while idx=2 in RUN.
        drive(vecs[4], 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", bus.busy, 0);
        chk("midrst done", bus.done, 0);
        chk("midrst result", bus.result, 0);
        chk("midrst carry_out", bus.carry_out, 1);
        chk("midrst a_eq_b", bus.a_eq_b, 0);
        chk("midrst alu_a", bus.alu_a, 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) seen++;
            @(negedge clk);
        end
        chk("midrst no_done", seen, 0);
        run_op(vecs[1], 9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_nibble_sequencer.md
# alu_nibble_sequencer

Sequential controller that runs WIDTH-bit operations on a single external 4-bit 74181-style ALU slice, one nibble per clock, LSB first. It sits directly upstream and downstream of the `top` ALU. It latches the wide operands and drives the slice's A/B/S/M/Cn inputs. It captures F, Cn_out and A_eq_B back into a wide result register, rippling carry between cycles.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4
- NIB (localparam), WIDTH/4, number of slice passes
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- sel  input  4  74181 function select S
- mode  input  1  74181 M (1 = logic, 0 = arithmetic)
- carry_in  input  1  74181 Cn for nibble 0, 74181 polarity (active-low carry)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  assembled F
- carry_out  output  1  Cn_out of the last nibble
- a_eq_b  output  1  AND of the A_eq_B outputs of all nibbles
- alu_a, alu_b  output  4  current nibble of latched A/B
- alu_s  output  4  latched sel
- alu_m  output  1  latched mode
- alu_cn  output  1  carry into the current nibble
- alu_f  input  4  slice F
- alu_cn_out  input  1  slice Cn_out
- alu_a_eq_b  input  1  slice A_eq_B

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1:
  - latch op_a, op_b, sel, mode, carry_in
  - idx <= 0; eq_acc <= 1
  - go to RUN.
- IDLE with start=0: hold.
- RUN, each cycle:
  - alu_a = a_lat[4*idx+:4], alu_b = b_lat[4*idx+:4], alu_cn = cy_reg (carry_in when idx=0).
  - At the edge: result[4*idx+:4] <= alu_f; cy_reg <= alu_cn_out; eq_acc <= eq_acc & alu_a_eq_b.
  - If idx = NIB-1: go to DONE. Otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored in RUN and DONE; it is not queued.
- carry_out = cy_reg and a_eq_b = eq_acc. Both are registered.
- result, carry_out and a_eq_b hold their values from DONE until the next accepted start.
- Carry is chained raw with no inversion. Polarity is whatever the 74181 convention for the selected function gives.
- In logic mode (M=1) the carry is still chained. carry_out is don't-care for checking.
- The block contains no arithmetic of its own, apart from the idx counter of width clog2(NIB), min 1.
- alu_* outputs are combinational from the latched registers and idx.
  - They are stable for the whole RUN cycle.
  - In IDLE/DONE they drive nibble 0 of the latched operands.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0
  - result=0, carry_out=1 (no-carry in 74181 polarity), a_eq_b=0
  - latched registers=0, idx=0
- Start is sampled at edge k. RUN occupies cycles k+1..k+NIB. done is high in cycle k+NIB+1.
- Total latency from the start edge to done is NIB+1 cycles; this is 5 for WIDTH=16.
- Back-to-back throughput: one operation per NIB+2 cycles. The earliest next start is sampled during the cycle after done.
- rst mid-RUN or in DONE:
  - returns to the reset values on the next edge
  - no done pulse is issued
  - partial results are cleared.
- The external slice must settle within one clock period. The path is alu_* out -> slice -> alu_f / alu_cn_out / alu_a_eq_b in.

## Configuration
- ALU_SEQ_ZERO_EN defined:
  - adds output `zero` (1 bit), registered, updated at the same edge as result.
  - zero = 1 iff the final result == 0.
  - Reset value is 0.
- ALU_SEQ_ZERO_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=16, S=1001, M=0, Cn=1, A=0x1234, B=0x0FCD -> done at start+5, result=0x2201, carry_out=1. busy is high for exactly 4 cycles. alu_a sequence is 4,3,2,1.
- S=1001, M=0, Cn=1, A=0xFFFF, B=0x0001 -> result=0x0000, carry_out=0. The carry must ripple through all 4 nibbles. zero=1 when ALU_SEQ_ZERO_EN is defined.
- S=0000, M=1, A=0xA5A5 -> result=0x5A5A. S=1011, M=1, A=0xA5A5, B=0x0FF0 -> result=0x05A0.
- S=0110, M=0, Cn=1, A=B=0x5555 -> result=0xFFFF, a_eq_b=1. Repeat with B=0x5554 -> a_eq_b=0.
- Pulse start again during RUN with different operands -> ignored; the first result is unchanged. Assert rst at RUN idx=2 -> no done pulse, all outputs at reset values next cycle, and a new start completes correctly.
